// File: rtl/bist_controller_if.sv
// Handshake and status bundle between the logic-BIST sequencer and its
// surroundings (MISR, pattern generator, test host).
interface bist_controller_if #(
    parameter int SIG_W = 12
);
    logic             start;
    logic             abort;
    logic [SIG_W-1:0] hf;
    logic             misr_rst;
    logic             bist_end;
    logic             prpg_en;
    logic             busy;
    logic             done;
    logic             pass;
    logic             fail;

    // Sequencer side
    modport master (
        input  start, abort, hf,
        output misr_rst, bist_end, prpg_en, busy, done, pass, fail
    );

    // Host / MISR / pattern-generator side
    modport slave (
        output start, abort, hf,
        input  misr_rst, bist_end, prpg_en, busy, done, pass, fail
    );
endinterface

// File: rtl/bist_controller.sv
// Logic-BIST sequencer: resets MISR and pattern generator, runs N_PATTERNS
// test cycles plus one MISR capture cycle, freezes the MISR, then compares
// the signature against GOLDEN and reports pass/fail.
module bist_controller #(
    parameter int                N_PATTERNS = 200,
    parameter int                CNT_W      = 16,
    parameter int                SIG_W      = 12,
    parameter logic [SIG_W-1:0]  GOLDEN     = '0
) (
    input  logic               CLK,
    input  logic               RST,
    bist_controller_if.master  bus
);

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        RUN,
        COMPARE,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_PATTERNS);

    state_t           state;
    logic [CNT_W-1:0] count;
    logic             misr_rst_q;
    logic             bist_end_q;
    logic             prpg_en_q;
    logic             busy_q;
    logic             done_q;
    logic             pass_q;
    logic             fail_q;

    // Sequencer FSM; every output is registered to the value the next state
    // decodes to, so outputs change on the same edge as the state.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= IDLE;
            count      <= '0;
            misr_rst_q <= 1'b1;
            bist_end_q <= 1'b1;
            prpg_en_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            fail_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state  <= INIT;
                        count  <= '0;
                        busy_q <= 1'b1;
                    end
                end

                INIT: begin
                    if (bus.abort) begin
                        state      <= DONE;
                        misr_rst_q <= 1'b0;
                        bist_end_q <= 1'b1;
                        prpg_en_q  <= 1'b0;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        pass_q     <= 1'b0;
                        fail_q     <= 1'b1;
                    end else begin
                        state      <= RUN;
                        count      <= '0;
                        misr_rst_q <= 1'b0;
                        bist_end_q <= 1'b0;
                        // First RUN cycle has count 0, always below N_PATTERNS (>= 1)
                        prpg_en_q  <= 1'b1;
                    end
                end

                RUN: begin
                    if (bus.abort) begin
                        state      <= DONE;
                        misr_rst_q <= 1'b0;
                        bist_end_q <= 1'b1;
                        prpg_en_q  <= 1'b0;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        pass_q     <= 1'b0;
                        fail_q     <= 1'b1;
                    end else if (count == LAST) begin
                        state      <= COMPARE;
                        bist_end_q <= 1'b1;
                        prpg_en_q  <= 1'b0;
                    end else begin
                        count     <= count + 1'b1;
                        // Registered form of prpg_en = (count < N_PATTERNS)
                        prpg_en_q <= ((count + 1'b1) < LAST);
                    end
                end

                COMPARE: begin
                    state      <= DONE;
                    misr_rst_q <= 1'b0;
                    bist_end_q <= 1'b1;
                    prpg_en_q  <= 1'b0;
                    busy_q     <= 1'b0;
                    done_q     <= 1'b1;
                    if (bus.abort) begin
                        pass_q <= 1'b0;
                        fail_q <= 1'b1;
                    end else begin
                        pass_q <= (bus.hf == GOLDEN);
                        fail_q <= (bus.hf != GOLDEN);
                    end
                end

                DONE: begin
                    // Hold the result until start is released, so a held
                    // start level cannot retrigger a run.
                    if (!bus.start) begin
                        state      <= IDLE;
                        misr_rst_q <= 1'b1;
                        bist_end_q <= 1'b1;
                        prpg_en_q  <= 1'b0;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b0;
                        pass_q     <= 1'b0;
                        fail_q     <= 1'b0;
                    end
                end

                default: begin
                    state      <= IDLE;
                    count      <= '0;
                    misr_rst_q <= 1'b1;
                    bist_end_q <= 1'b1;
                    prpg_en_q  <= 1'b0;
                    busy_q     <= 1'b0;
                    done_q     <= 1'b0;
                    pass_q     <= 1'b0;
                    fail_q     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.misr_rst = misr_rst_q;
    assign bus.bist_end = bist_end_q;
    assign bus.prpg_en  = prpg_en_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.pass     = pass_q;
    assign bus.fail     = fail_q;

endmodule

// File: doc/bist_controller.md
# bist_controller

Sequencer for the logic-BIST loop: pattern generator -> circuit under test -> 12-bit MISR. On a start request it resets the MISR and pattern generator, runs a programmed number of test cycles, freezes the MISR, compares the final signature against a golden value and reports pass/fail. It sits above the MISR and drives that block's RST and bist_end inputs.

## Interface
- N_PATTERNS, 200: number of test patterns applied per run (>= 1)
- CNT_W, 16: pattern counter width; N_PATTERNS+1 must fit in CNT_W bits
- SIG_W, 12: signature width; matches MISR hf
- GOLDEN, 12'h000: expected fault-free signature (set per CUT at instantiation)

- CLK  in  1  system clock, rising edge
- RST  in  1  asynchronous, active-low reset of this block
- start  in  1  level request; sampled in IDLE and DONE only
- abort  in  1  synchronous abort of a run in progress
- hf  in  SIG_W  MISR signature output
- misr_rst  out  1  active-high synchronous reset to MISR RST and pattern generator
- bist_end  out  1  MISR freeze; 0 = compacting, 1 = hold
- prpg_en  out  1  pattern generator advance enable
- busy  out  1  run in progress (INIT, RUN, COMPARE)
- done  out  1  result valid
- pass  out  1  signature == GOLDEN; valid when done=1
- fail  out  1  signature != GOLDEN or run aborted; valid when done=1

## Operation
- States: IDLE, INIT, RUN, COMPARE, DONE. Registered state, counter and result flags; outputs decoded from state, plus the registered pass/fail.
- IDLE: misr_rst=1, bist_end=1, prpg_en=0, busy=0, done=0. start=1 -> INIT.
- INIT (1 cycle): misr_rst=1, bist_end=1, busy=1; counter cleared to 0. -> RUN.
- RUN: misr_rst=0, bist_end=0, prpg_en=1, busy=1; counter increments every cycle. Lasts N_PATTERNS+1 cycles. The extra cycle lets the MISR register the final state into hf, since hf only updates while bist_end=0. prpg_en drops in the final RUN cycle: prpg_en = (count < N_PATTERNS). Exit when count == N_PATTERNS -> COMPARE.
- COMPARE (1 cycle): bist_end=1, misr_rst=0, busy=1. On exit: pass <= (hf == GOLDEN), fail <= (hf != GOLDEN). -> DONE.
- DONE: done=1, busy=0, bist_end=1, misr_rst=0, so hf holds the signature for readout. pass/fail held. start=0 -> IDLE.
  - Start must be deasserted before a new run begins; a new run needs start low, then high.
- abort=1 in INIT, RUN or COMPARE: -> DONE with pass=0, fail=1 on the next edge. abort is ignored in IDLE and DONE.
- start changes in INIT/RUN/COMPARE are ignored.
- pass and fail are never both 1. Both are 0 except in DONE.

## Timing
- Reset (RST=0, async): state=IDLE, counter=0, pass=0, fail=0. Outputs: misr_rst=1, bist_end=1, prpg_en=0, busy=0, done=0. Takes effect immediately, including mid-run. After RST releases, the first possible transition is at the next rising edge.
- Edge e0 samples start=1 in IDLE -> INIT.
- e1 -> RUN.
- e2 .. e(N_PATTERNS+2): RUN, N_PATTERNS+1 cycles with bist_end=0.
- e(N_PATTERNS+2) -> COMPARE.
- e(N_PATTERNS+3) -> DONE. done/pass/fail are valid after this edge.
- Start-to-done latency: N_PATTERNS+3 cycles. prpg_en is high for exactly N_PATTERNS cycles.
- abort sampled at edge k -> done=1, fail=1 after edge k; bist_end=1 from the same edge.
- Counter never wraps; its compare uses the full CNT_W width.

## Test plan
- Reset values: RST=0 mid-RUN (N_PATTERNS=4) -> misr_rst=1, bist_end=1, busy=0, done=0, pass=fail=0 asynchronously; after release, stays IDLE while start=0.
- Pass run: N_PATTERNS=4, GOLDEN=12'hA5C, hf model reaches 12'hA5C at the last RUN edge, start pulse at e0.
  - Expected: bist_end low for exactly 5 cycles (e2-e6), prpg_en high for 4 cycles, done=1 and pass=1 after e7, hf stable in DONE.
- Fail run: same setup, hf=12'hA5D -> done=1, pass=0, fail=1 after e7.
- Abort: abort=1 at the 2nd RUN cycle -> DONE next edge with fail=1, pass=0, bist_end=1, prpg_en=0.
- Start handshake: start held high through DONE -> remains in DONE (no restart). Drop start -> IDLE; raise start again -> INIT, new run with misr_rst pulsed 1 cycle after IDLE.
- N_PATTERNS=1 boundary: RUN lasts 2 cycles, prpg_en high 1 cycle, done 4 cycles after the start edge.
